// File: rtl/mfp_irq_ctrl_if.sv
// Bus interface of the MFP interrupt controller: register port, source
// inputs and interrupt-acknowledge handshake. The slave modport is the
// controller side, the master modport is the CPU/source side.
interface mfp_irq_ctrl_if;
    logic [15:0] SRC_I;
    logic [3:0]  ADDR;
    logic        WE;
    logic [7:0]  DAT_I;
    logic [7:0]  DAT_O;
    logic        IACK_I;
    logic        ACK_O;
    logic [7:0]  VECTOR_O;
    logic        IRQ_O;

    modport slave (
        input  SRC_I, ADDR, WE, DAT_I, IACK_I,
        output DAT_O, ACK_O, VECTOR_O, IRQ_O
    );

    modport master (
        output SRC_I, ADDR, WE, DAT_I, IACK_I,
        input  DAT_O, ACK_O, VECTOR_O, IRQ_O
    );
endinterface

// File: rtl/mfp_irq_ctrl.sv
// MFP-style 16-channel prioritised interrupt controller.
// Rising edges on enabled sources set pending bits; pending & mask bits
// compete on channel number (15 highest). An acknowledge latches a vector
// {VR[7:4], channel} and retires the winning pending bit.
// Optional in-service tracking is enabled by defining MFP_IRQ_ISR_EN; without
// it ISR does not exist, VR[3] reads 0 and every acknowledge is an automatic
// end-of-interrupt.
module mfp_irq_ctrl #(
    parameter logic [7:0] VEC_RESET = 8'h00
) (
    input  logic              CLK,
    input  logic              RST,
    mfp_irq_ctrl_if.slave     bus
);
    localparam logic [3:0] A_IERA = 4'd0;
    localparam logic [3:0] A_IERB = 4'd1;
    localparam logic [3:0] A_IPRA = 4'd2;
    localparam logic [3:0] A_IPRB = 4'd3;
    localparam logic [3:0] A_ISRA = 4'd4;
    localparam logic [3:0] A_ISRB = 4'd5;
    localparam logic [3:0] A_IMRA = 4'd6;
    localparam logic [3:0] A_IMRB = 4'd7;
    localparam logic [3:0] A_VR   = 4'd8;

    logic [15:0] ier_r, ipr_r, imr_r, src_q_r;
    logic [7:3]  vr_r;
    logic        ack_r, irq_r;
    logic [7:0]  vector_r;

    logic [15:0] ier_n_s, ipr_n_s, imr_n_s;
    logic [7:3]  vr_n_s;
    logic [15:0] req_s, cand_s, edge_s;
    logic        win_valid_s, accept_s;
    logic [3:0]  win_idx_s;
    logic [7:0]  dat_o_s;

`ifdef MFP_IRQ_ISR_EN
    logic [15:0] isr_r, isr_n_s;

    // Marks the highest set bit and every bit below it; the complement is
    // the set of channels allowed to preempt the current service level.
    function automatic logic [15:0] smear_down(input logic [15:0] v);
        logic [15:0] s;
        s[15] = v[15];
        for (int i = 14; i >= 0; i--) begin
            s[i] = v[i] | s[i+1];
        end
        return s;
    endfunction
`endif

    // Priority resolution, edge detection and acknowledge qualification.
    always_comb begin
        req_s = ipr_r & imr_r;
`ifdef MFP_IRQ_ISR_EN
        cand_s = req_s & ~smear_down(isr_r);
`else
        cand_s = req_s;
`endif
        win_valid_s = |cand_s;
        win_idx_s   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            win_idx_s = cand_s[i] ? i[3:0] : win_idx_s;
        end
        accept_s = bus.IACK_I & win_valid_s;
        edge_s   = bus.SRC_I & ~src_q_r & ier_r;
    end

    // Next-state of the register file: writes first, then acknowledge
    // effects, then source edges so that a new edge always wins over a clear.
    always_comb begin
        ier_n_s = ier_r;
        ipr_n_s = ipr_r;
        imr_n_s = imr_r;
        vr_n_s  = vr_r;
`ifdef MFP_IRQ_ISR_EN
        isr_n_s = isr_r;
`endif
        if (bus.WE) begin
            case (bus.ADDR)
                A_IERA: begin
                    ier_n_s[15:8] = bus.DAT_I;
                    ipr_n_s[15:8] = ipr_r[15:8] & bus.DAT_I;
                end
                A_IERB: begin
                    ier_n_s[7:0] = bus.DAT_I;
                    ipr_n_s[7:0] = ipr_r[7:0] & bus.DAT_I;
                end
                A_IPRA: ipr_n_s[15:8] = ipr_r[15:8] & bus.DAT_I;
                A_IPRB: ipr_n_s[7:0]  = ipr_r[7:0] & bus.DAT_I;
`ifdef MFP_IRQ_ISR_EN
                A_ISRA: isr_n_s[15:8] = isr_r[15:8] & bus.DAT_I;
                A_ISRB: isr_n_s[7:0]  = isr_r[7:0] & bus.DAT_I;
`endif
                A_IMRA: imr_n_s[15:8] = bus.DAT_I;
                A_IMRB: imr_n_s[7:0]  = bus.DAT_I;
                A_VR: begin
`ifdef MFP_IRQ_ISR_EN
                    vr_n_s  = bus.DAT_I[7:3];
                    // Dropping the S bit abandons all in-service tracking.
                    isr_n_s = bus.DAT_I[3] ? isr_r : 16'h0000;
`else
                    vr_n_s  = {bus.DAT_I[7:4], 1'b0};
`endif
                end
                default: vr_n_s = vr_r;
            endcase
        end else begin
            vr_n_s = vr_r;
        end
        ipr_n_s = ipr_n_s & ~(accept_s ? (16'h0001 << win_idx_s) : 16'h0000);
`ifdef MFP_IRQ_ISR_EN
        isr_n_s = isr_n_s | ((accept_s & vr_r[3]) ? (16'h0001 << win_idx_s) : 16'h0000);
`endif
        ipr_n_s = ipr_n_s | edge_s;
    end

    // State and output registers; reset preloads the source copy high so a
    // source that is already high is not seen as a fresh edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ier_r    <= 16'h0000;
            ipr_r    <= 16'h0000;
            imr_r    <= 16'h0000;
`ifdef MFP_IRQ_ISR_EN
            isr_r    <= 16'h0000;
            vr_r     <= VEC_RESET[7:3];
`else
            vr_r     <= {VEC_RESET[7:4], 1'b0};
`endif
            src_q_r  <= 16'hFFFF;
            irq_r    <= 1'b0;
            ack_r    <= 1'b0;
            vector_r <= 8'h00;
        end else begin
            ier_r    <= ier_n_s;
            ipr_r    <= ipr_n_s;
            imr_r    <= imr_n_s;
`ifdef MFP_IRQ_ISR_EN
            isr_r    <= isr_n_s;
`endif
            vr_r     <= vr_n_s;
            src_q_r  <= bus.SRC_I;
            // The acknowledged channel is retiring, so the request drops now.
            irq_r    <= win_valid_s & ~accept_s;
            ack_r    <= accept_s;
            vector_r <= accept_s ? {vr_r[7:4], win_idx_s} : vector_r;
        end
    end

    // Register read-back multiplexer.
    always_comb begin
        dat_o_s = 8'h00;
        case (bus.ADDR)
            A_IERA: dat_o_s = ier_r[15:8];
            A_IERB: dat_o_s = ier_r[7:0];
            A_IPRA: dat_o_s = ipr_r[15:8];
            A_IPRB: dat_o_s = ipr_r[7:0];
`ifdef MFP_IRQ_ISR_EN
            A_ISRA: dat_o_s = isr_r[15:8];
            A_ISRB: dat_o_s = isr_r[7:0];
`endif
            A_IMRA: dat_o_s = imr_r[15:8];
            A_IMRB: dat_o_s = imr_r[7:0];
            A_VR:   dat_o_s = {vr_r, 3'b000};
            default: dat_o_s = 8'h00;
        endcase
    end

    assign bus.DAT_O    = dat_o_s;
    assign bus.ACK_O    = ack_r;
    assign bus.VECTOR_O = vector_r;
    assign bus.IRQ_O    = irq_r;
endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Self-checking bench for mfp_irq_ctrl. Acknowledge vectors are pushed to a
// scoreboard queue when IACK_I is driven and popped when ACK_O is seen.
// Expectations follow the MFP_IRQ_ISR_EN build setting.
`timescale 1ns/100ps
module tb_mfp_irq_ctrl;
`ifdef MFP_IRQ_ISR_EN
    localparam bit ISR_EN = 1'b1;
`else
    localparam bit ISR_EN = 1'b0;
`endif
    localparam logic [7:0] VRST = 8'hAF;

    logic clk;
    logic rst;
    mfp_irq_ctrl_if bus ();

    mfp_irq_ctrl #(.VEC_RESET(VRST)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rv;
    logic [7:0] ev;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.ADDR  = a;
        bus.DAT_I = d;
        bus.WE    = 1'b1;
        tick();
        bus.WE    = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.ADDR = a;
        #1;
        d = bus.DAT_O;
    endtask

    // Drive one acknowledge cycle and record the vector it must produce.
    task automatic iack(input logic [7:0] exp_vec);
        exp_q.push_back(exp_vec);
        bus.IACK_I = 1'b1;
        tick();
        bus.IACK_I = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.WE = 1'b0; bus.IACK_I = 1'b0; bus.SRC_I = 16'h0000;
        bus.ADDR = 4'd0; bus.DAT_I = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.IRQ_O !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", bus.IRQ_O); end
        checks++; if (bus.ACK_O !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", bus.ACK_O); end
        checks++; if (bus.VECTOR_O !== 8'h00) begin errors++; $display("FAIL rst_vec got=%h exp=00", bus.VECTOR_O); end
        for (int a = 0; a < 8; a++) begin
            rd(a[3:0], rv);
            checks++; if (rv !== 8'h00) begin errors++; $display("FAIL rst_reg%0d got=%h exp=00", a, rv); end
        end
        ev = ISR_EN ? {VRST[7:3], 3'b000} : {VRST[7:4], 4'b0000};
        rd(4'd8, rv);
        checks++; if (rv !== ev) begin errors++; $display("FAIL rst_vr got=%h exp=%h", rv, ev); end
        rd(4'd9, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL addr9 got=%h exp=00", rv); end
        rd(4'd15, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL addr15 got=%h exp=00", rv); end
    endtask

    task automatic test_enable();
        wr(4'd6, 8'hFF);
        bus.SRC_I = 16'h0400; tick();
        bus.SRC_I = 16'h0000; tick();
        rd(4'd2, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL disabled_edge got=%h exp=00", rv); end
        checks++; if (bus.IRQ_O !== 1'b0) begin errors++; $display("FAIL disabled_irq got=%b exp=0", bus.IRQ_O); end
        wr(4'd0, 8'hFF);
        bus.SRC_I = 16'h0200; tick();
        bus.SRC_I = 16'h0000;
        rd(4'd2, rv);
        checks++; if (rv !== 8'h02) begin errors++; $display("FAIL enabled_edge got=%h exp=02", rv); end
        wr(4'd0, 8'hFD);
        rd(4'd2, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL ier_clr_ipr got=%h exp=00", rv); end
        rd(4'd0, rv);
        checks++; if (rv !== 8'hFD) begin errors++; $display("FAIL ier_load got=%h exp=FD", rv); end
        wr(4'd0, 8'h00);
        wr(4'd6, 8'h00);
    endtask

    task automatic test_edge_irq();
        wr(4'd0, 8'h20);
        wr(4'd6, 8'h20);
        bus.SRC_I = 16'h2000; tick();
        bus.SRC_I = 16'h0000;
        rd(4'd2, rv);
        checks++; if (rv !== 8'h20) begin errors++; $display("FAIL ipra_set got=%h exp=20", rv); end
        checks++; if (bus.IRQ_O !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", bus.IRQ_O); end
        tick();
        checks++; if (bus.IRQ_O !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", bus.IRQ_O); end
    endtask

    task automatic test_iack();
        wr(4'd8, 8'h48);
        rd(4'd8, rv);
        ev = ISR_EN ? 8'h48 : 8'h40;
        checks++; if (rv !== ev) begin errors++; $display("FAIL vr_read got=%h exp=%h", rv, ev); end
        iack(8'h4D);
        checks++; if (bus.ACK_O !== 1'b1) begin errors++; $display("FAIL iack_ack got=%b exp=1", bus.ACK_O); end
        else begin
            ev = exp_q.pop_front();
            checks++; if (bus.VECTOR_O !== ev) begin errors++; $display("FAIL iack_vec got=%h exp=%h", bus.VECTOR_O, ev); end
        end
        checks++; if (bus.IRQ_O !== 1'b0) begin errors++; $display("FAIL iack_irq got=%b exp=0", bus.IRQ_O); end
        rd(4'd2, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL iack_ipra got=%h exp=00", rv); end
        rd(4'd4, rv);
        ev = ISR_EN ? 8'h20 : 8'h00;
        checks++; if (rv !== ev) begin errors++; $display("FAIL iack_isra got=%h exp=%h", rv, ev); end
        tick();
        checks++; if (bus.ACK_O !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got=%b exp=0", bus.ACK_O); end
        checks++; if (bus.VECTOR_O !== 8'h4D) begin errors++; $display("FAIL vec_hold got=%h exp=4D", bus.VECTOR_O); end
    endtask

    task automatic test_nesting();
        wr(4'd1, 8'h20);
        wr(4'd7, 8'h20);
        bus.SRC_I = 16'h0020; tick();
        bus.SRC_I = 16'h0000; tick();
        ev = ISR_EN ? 8'h00 : 8'h01;
        checks++; if (bus.IRQ_O !== ev[0]) begin errors++; $display("FAIL nest_blocked got=%b exp=%b", bus.IRQ_O, ev[0]); end
        wr(4'd4, 8'hDF);
        checks++; if (bus.IRQ_O !== ev[0]) begin errors++; $display("FAIL nest_wr_edge got=%b exp=%b", bus.IRQ_O, ev[0]); end
        tick();
        checks++; if (bus.IRQ_O !== 1'b1) begin errors++; $display("FAIL nest_release got=%b exp=1", bus.IRQ_O); end
        iack(8'h45);
        checks++; if (bus.ACK_O !== 1'b1) begin errors++; $display("FAIL nest_ack got=%b exp=1", bus.ACK_O); end
        else begin
            ev = exp_q.pop_front();
            checks++; if (bus.VECTOR_O !== ev) begin errors++; $display("FAIL nest_vec got=%h exp=%h", bus.VECTOR_O, ev); end
        end
        wr(4'd4, 8'h00);
        wr(4'd5, 8'h00);
    endtask

    task automatic test_simultaneous();
        wr(4'd1, 8'h01);
        wr(4'd7, 8'h01);
        bus.SRC_I = 16'h0001; tick();
        bus.SRC_I = 16'h0000;
        wr(4'd3, 8'hFE);
        rd(4'd3, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL iprb_clear got=%h exp=00", rv); end
        bus.SRC_I = 16'h0001;
        wr(4'd3, 8'hFE);
        bus.SRC_I = 16'h0000;
        rd(4'd3, rv);
        checks++; if (rv !== 8'h01) begin errors++; $display("FAIL edge_vs_wr got=%h exp=01", rv); end
        tick();
        bus.SRC_I = 16'h0001;
        iack(8'h40);
        bus.SRC_I = 16'h0000;
        checks++; if (bus.ACK_O !== 1'b1) begin errors++; $display("FAIL edge_iack_ack got=%b exp=1", bus.ACK_O); end
        else begin
            ev = exp_q.pop_front();
            checks++; if (bus.VECTOR_O !== ev) begin errors++; $display("FAIL edge_iack_vec got=%h exp=%h", bus.VECTOR_O, ev); end
        end
        rd(4'd3, rv);
        checks++; if (rv !== 8'h01) begin errors++; $display("FAIL edge_vs_iack got=%h exp=01", rv); end
        wr(4'd5, 8'h00);
        bus.ADDR = 4'd5; bus.DAT_I = 8'h00; bus.WE = 1'b1;
        iack(8'h40);
        bus.WE = 1'b0;
        checks++; if (bus.ACK_O !== 1'b1) begin errors++; $display("FAIL isr_race_ack got=%b exp=1", bus.ACK_O); end
        else begin
            ev = exp_q.pop_front();
            checks++; if (bus.VECTOR_O !== ev) begin errors++; $display("FAIL isr_race_vec got=%h exp=%h", bus.VECTOR_O, ev); end
        end
        rd(4'd5, rv);
        ev = ISR_EN ? 8'h01 : 8'h00;
        checks++; if (rv !== ev) begin errors++; $display("FAIL isr_set_vs_wr got=%h exp=%h", rv, ev); end
        wr(4'd5, 8'h00);
        bus.IACK_I = 1'b1; tick(); bus.IACK_I = 1'b0;
        checks++; if (bus.ACK_O !== 1'b0) begin errors++; $display("FAIL nowin_ack got=%b exp=0", bus.ACK_O); end
        checks++; if (bus.VECTOR_O !== 8'h40) begin errors++; $display("FAIL nowin_vec got=%h exp=40", bus.VECTOR_O); end
    endtask

    task automatic test_back_to_back();
        wr(4'd0, 8'hFF); wr(4'd1, 8'hFF);
        wr(4'd6, 8'hFF); wr(4'd7, 8'hFF);
        wr(4'd8, 8'h40);
        bus.SRC_I = 16'h1008; tick();
        bus.SRC_I = 16'h0000; tick();
        exp_q.push_back(8'h4C);
        exp_q.push_back(8'h43);
        bus.IACK_I = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++; if (bus.ACK_O !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d got=%b exp=1", n, bus.ACK_O); end
            else begin
                ev = exp_q.pop_front();
                checks++; if (bus.VECTOR_O !== ev) begin errors++; $display("FAIL b2b_vec%0d got=%h exp=%h", n, bus.VECTOR_O, ev); end
            end
        end
        bus.IACK_I = 1'b0;
        tick();
        checks++; if (bus.ACK_O !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", bus.ACK_O); end
        checks++; if (bus.IRQ_O !== 1'b0) begin errors++; $display("FAIL b2b_irq got=%b exp=0", bus.IRQ_O); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        bus.SRC_I = 16'hFFFF; tick(); tick();
        checks++; if (bus.IRQ_O !== 1'b1) begin errors++; $display("FAIL pre_rst_irq got=%b exp=1", bus.IRQ_O); end
        rst = 1'b1; bus.IACK_I = 1'b1; bus.WE = 1'b1; bus.ADDR = 4'd0; bus.DAT_I = 8'h5A;
        tick();
        rst = 1'b0; bus.IACK_I = 1'b0; bus.WE = 1'b0;
        checks++; if (bus.ACK_O !== 1'b0) begin errors++; $display("FAIL rst_ack_drop got=%b exp=0", bus.ACK_O); end
        checks++; if (bus.IRQ_O !== 1'b0) begin errors++; $display("FAIL rst_irq_drop got=%b exp=0", bus.IRQ_O); end
        checks++; if (bus.VECTOR_O !== 8'h00) begin errors++; $display("FAIL rst_vec_clr got=%h exp=00", bus.VECTOR_O); end
        rd(4'd0, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL rst_over_we got=%h exp=00", rv); end
        wr(4'd0, 8'hFF); wr(4'd1, 8'hFF);
        wr(4'd6, 8'hFF); wr(4'd7, 8'hFF);
        tick(); tick();
        rd(4'd2, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL post_rst_ipra got=%h exp=00", rv); end
        rd(4'd3, rv);
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL post_rst_iprb got=%h exp=00", rv); end
        checks++; if (bus.IRQ_O !== 1'b0) begin errors++; $display("FAIL post_rst_irq got=%b exp=0", bus.IRQ_O); end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_edge_irq();
        test_iack();
        test_nesting();
        test_simultaneous();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
